switch_fifo: RTL and testbench

SWITCH_FIFO -- requirements
Module: switch_fifo

---
 rtl/switch_fifo.sv | 99 +++++++++
 tb/tb_switch_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/switch_fifo.sv
// Synchronous single-clock FIFO with registered read data and occupancy flags.
// Optional sticky overflow/underflow flags are enabled by SWITCH_FIFO_ERR_FLAGS_EN.
module switch_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_LEVEL   = DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dout_valid_q;
  logic                  wr_acc, rd_acc;

  // Flags decode from the count register only, so they never glitch on input activity.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign dout         = dout_q;
  assign dout_valid   = dout_valid_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      dout_valid_q <= rd_acc;
      if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        dout_q   <= mem[rd_ptr_q];
      end
    end
  end

  // Storage is not reset; words behind the pointers are unreachable after reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= din;
  end

`ifdef SWITCH_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full)  overflow_q  <= 1'b1;
      if (rd_en && empty) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_switch_fifo.sv
// Self-checking bench for switch_fifo: vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_switch_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0] count;

  switch_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .din         (din),
    .rd_en       (rd_en),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_valid = 1'b0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  typedef struct {
    bit            wr;
    bit            rd;
    logic [DW-1:0] d;
    int            exp_count;
    bit            exp_valid;
    logic [DW-1:0] exp_dout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("dout", 32'(dout), 32'(m_dout));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  task automatic step(input bit w, input bit r, input logic [DW-1:0] d);
    bit racc, wacc;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
`ifdef SWITCH_FIFO_ERR_FLAGS_EN
    if (w && q.size() == DEPTH) m_ovf = 1'b1;
    if (r && q.size() == 0) m_unf = 1'b1;
`endif
    racc = r && (q.size() > 0);
    wacc = w && (q.size() < DEPTH);
    m_valid = racc;
    if (racc) m_dout = q.pop_front();
    if (wacc) q.push_back(d);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 8'hAA, 1, 1'b0, 8'h00};  // empty: write only, no bypass
    vecs[1] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 8'hAA};
    vecs[2] = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 8'hAA};  // dout held
    vecs[3] = '{1'b1, 1'b0, 8'h22, 2, 1'b0, 8'hAA};
    vecs[4] = '{1'b1, 1'b1, 8'h33, 2, 1'b1, 8'h11};  // simultaneous
    vecs[5] = '{1'b0, 1'b1, 8'h00, 1, 1'b1, 8'h22};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h33};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h33};  // read at empty ignored

    // Reset values, no clock needed
    #2;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].d);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_valid", i), 32'(dout_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
    end

    // Fill and drain, thresholds checked at every count
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    step(1'b1, 1'b0, 8'hEF);  // write at full dropped
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("drain_order", 32'(dout), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Full with simultaneous read and write: only the read happens
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    step(1'b1, 1'b1, 8'hEE);
    chk("full_rw_count", 32'(count), 32'd15);
    for (int i = 0; i < DEPTH - 1; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("full_rw_no_extra", 32'(dout == 8'hEE), 32'd0);
    end

    // Wrap-around
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("wrap_order", 32'(dout), 32'(8'hC0 + i));
    end
    chk("wrap_count", 32'(count), 32'd0);

    // Reset in mid-operation at count 7, with a read pending
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_dout", 32'(dout), 32'd0);
    chk("midrst_valid", 32'(dout_valid), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    chk("midrst_unf", 32'(underflow), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    rd_en = 1'b0;
    step(1'b1, 1'b0, 8'h5A);
    step(1'b0, 1'b1, 8'h00);
    chk("postrst_dout", 32'(dout), 32'h5A);

    // Randomized traffic with shifting write bias
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i < 200) ? 70 : (i < 400) ? 30 : 50;
      step($urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias),
           8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
